half_scale_ctrl: RTL and testbench
==================================

Name: half_scale_ctrl

Overview:
- Sequencer that drives one shared modular_half datapath over a whole polynomial held in an external single-port-style coefficient RAM.
- Each coefficient word is halved modulo q a programmable number of times (multiply by 2^-s mod q), e.g. the final n^-1 scaling after INTT.
- Supports K mode (two packed 12-bit coeffs per 24-bit word, q=3329) and D mode (one 23-bit coeff per word, q=8380417).
- Sits between the polynomial RAM and the modular_half instance; the top-level NTT controller starts it.

Parameters:
- data_width, 24, RAM word / datapath width.
- addr_width, 8, RAM address width.
- n_words_K, 128, words per polynomial in K mode (256 coeffs packed 2 per word).
- n_words_D, 256, words per polynomial in D mode.
- cnt_width, 4, width of shift count (max 15 halvings).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request; honoured only in IDLE.
- KD_mode  in  1  0=K, 1=D; sampled at accepted start.
- shift_cnt  in  cnt_width  number of halvings s; sampled at accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when job finished.
- rd_en  out  1  RAM read strobe.
- rd_addr  out  addr_width  RAM read address.
- rd_data  in  data_width  RAM read data, valid the cycle after rd_en.
- half_x  out  data_width  operand to modular_half.
- half_mode  out  1  KD_mode to modular_half (latched copy).
- half_y  in  data_width  combinational result from modular_half.
- wr_en  out  1  RAM write strobe.
- wr_addr  out  addr_width  RAM write address.
- wr_data  out  data_width  RAM write data.

Behaviour:
- Reset (sync, rst=1 at clock edge): state=IDLE; busy, done, rd_en, wr_en=0; rd_addr, wr_addr, wr_data, half_x (acc), word counter, iteration counter = 0; half_mode=0.
- Reset mid-job: same as above on the next edge; the job is abandoned and no further writes occur. Words already written stay written.
- Job start: in IDLE with start=1, latch mode and s, clear addr to 0, go to READ. start is ignored in all other states, with no effect on the running job.
- READ (1 cycle): rd_en=1, rd_addr=addr. Go to WAIT.
- WAIT (1 cycle): acc <= rd_data; iter <= 0. Go to HALVE if s>0, else WRITE.
- HALVE (s cycles): half_x=acc; acc <= half_y each cycle; iter increments. Leave to WRITE when iter==s-1.
- WRITE (1 cycle): wr_en=1, wr_addr=addr, wr_data=acc.
  - If addr==N-1 (N=n_words_K or n_words_D per latched mode), go to DONE.
  - Otherwise addr+1 and go to READ.
- DONE (1 cycle): done=1, busy=1, then IDLE.
- Per-word cost is 3+s cycles. Busy duration is N*(3+s)+1 cycles (includes DONE).
- s=0: the job is a pure copy; the word is written unchanged.
- The address counter never wraps past N-1. N is fixed by the latched mode, so a KD_mode change mid-job has no effect.
- half_x always equals acc, and half_mode always equals the latched mode, including in IDLE.
- rd_en and wr_en are never asserted in the same cycle.

Optional Feature:
- Macro HALF_SCALE_PERF_EN.
- Defined: adds output perf_cycles [31:0].
  - Cleared to 0 on an accepted start.
  - Increments every cycle busy=1, and holds its value in IDLE.
  - Reset to 0 by rst.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- D mode, s=1, word0=3 -> WRITE of addr0 with wr_data=4190210; 256 writes; done pulses once; busy lasts 256*4+1=1025 cycles.
- D mode, s=2, word0=1 -> wr_data=6285313 (6285313*4 ≡ 1 mod 8380417); each word spends exactly 2 HALVE cycles.
- K mode, s=1, word0={12'd5,12'd4} -> wr_data={12'd1667,12'd2}; last write at addr 127; no rd_en at addr 128.
- s=0, any mode -> every wr_data equals the rd_data read from the same address; 3 cycles per word.
- start re-asserted while busy, and KD_mode toggled mid-job -> no restart, N unchanged, single done pulse.
- rst=1 during HALVE of word 10 -> next cycle IDLE with all outputs 0; no write to addr 10; a fresh start then runs normally from addr 0 (with HALF_SCALE_PERF_EN, perf_cycles=0 after reset).

Source files
------------

// File: rtl/half_scale_if.sv
// Bundle between half_scale_ctrl, its NTT-controller start handshake, the coefficient RAM and modular_half.
// The master modport is the sequencer side; the slave modport is the environment side.
interface half_scale_if #(
   parameter int DATA_W = 24,
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 4
);
   logic              start;
   logic              KD_mode;
   logic [CNT_W-1:0]  shift_cnt;
   logic              busy;
   logic              done;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] half_x;
   logic              half_mode;
   logic [DATA_W-1:0] half_y;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   modport master (
      input  start, KD_mode, shift_cnt, rd_data, half_y,
      output busy, done, rd_en, rd_addr, half_x, half_mode, wr_en, wr_addr, wr_data
   );

   modport slave (
      output start, KD_mode, shift_cnt, rd_data, half_y,
      input  busy, done, rd_en, rd_addr, half_x, half_mode, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/half_scale_ctrl.sv
// Sequencer that halves every word of a polynomial s times mod q through one shared modular_half.
// Optional macro HALF_SCALE_PERF_EN adds a perf_cycles output counting busy cycles of the last job.
module half_scale_ctrl #(
   parameter int DATA_W    = 24,
   parameter int ADDR_W    = 8,
   parameter int N_WORDS_K = 128,
   parameter int N_WORDS_D = 256,
   parameter int CNT_W     = 4
) (
   input  logic          clk,
   input  logic          rst,
   half_scale_if.master  bus
`ifdef HALF_SCALE_PERF_EN
   ,
   output logic [31:0]   perf_cycles
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_HALVE,
      S_WRITE,
      S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(N_WORDS_K - 1);
   localparam logic [ADDR_W-1:0] LAST_D = ADDR_W'(N_WORDS_D - 1);

   state_t            state_q, state_d;
   logic              mode_q, mode_d;
   logic [CNT_W-1:0]  s_q, s_d;
   logic [CNT_W-1:0]  iter_q, iter_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              rd_en_q, rd_en_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] last_addr;
`ifdef HALF_SCALE_PERF_EN
   logic [31:0]       perf_q, perf_d;
`endif

   // Word count is fixed by the mode latched at start, so KD_mode changes mid-job are harmless.
   assign last_addr = mode_q ? LAST_D : LAST_K;

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      s_d     = s_q;
      iter_d  = iter_q;
      addr_d  = addr_q;
      acc_d   = acc_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               mode_d  = bus.KD_mode;
               s_d     = bus.shift_cnt;
               addr_d  = '0;
               state_d = S_READ;
            end
         end
         S_READ: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            acc_d   = bus.rd_data;
            iter_d  = '0;
            state_d = (s_q != '0) ? S_HALVE : S_WRITE;
         end
         S_HALVE: begin
            acc_d  = bus.half_y;
            iter_d = iter_q + 1'b1;
            if (iter_q == s_q - 1'b1) begin
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (addr_q == last_addr) begin
               state_d = S_DONE;
            end else begin
               addr_d  = addr_q + 1'b1;
               state_d = S_READ;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs are registered by decoding the next state, so strobes line up with the state they belong to.
   always_comb begin
      busy_d    = (state_d != S_IDLE);
      done_d    = (state_d == S_DONE);
      rd_en_d   = (state_d == S_READ);
      wr_en_d   = (state_d == S_WRITE);
      rd_addr_d = (state_d == S_READ)  ? addr_d : rd_addr_q;
      wr_addr_d = (state_d == S_WRITE) ? addr_d : wr_addr_q;
      wr_data_d = (state_d == S_WRITE) ? acc_d  : wr_data_q;
   end

`ifdef HALF_SCALE_PERF_EN
   always_comb begin
      perf_d = perf_q;
      if (state_q == S_IDLE && bus.start) begin
         perf_d = '0;
      end else if (busy_q) begin
         perf_d = perf_q + 32'd1;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         mode_q    <= 1'b0;
         s_q       <= '0;
         iter_q    <= '0;
         addr_q    <= '0;
         acc_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rd_en_q   <= 1'b0;
         wr_en_q   <= 1'b0;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
`ifdef HALF_SCALE_PERF_EN
         perf_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         s_q       <= s_d;
         iter_q    <= iter_d;
         addr_q    <= addr_d;
         acc_q     <= acc_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         rd_en_q   <= rd_en_d;
         wr_en_q   <= wr_en_d;
         rd_addr_q <= rd_addr_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
`ifdef HALF_SCALE_PERF_EN
         perf_q    <= perf_d;
`endif
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.rd_en     = rd_en_q;
   assign bus.rd_addr   = rd_addr_q;
   assign bus.wr_en     = wr_en_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.half_x    = acc_q;
   assign bus.half_mode = mode_q;
`ifdef HALF_SCALE_PERF_EN
   assign perf_cycles   = perf_q;
`endif

endmodule

// File: tb/tb_half_scale_ctrl.sv
// Scoreboard bench for half_scale_ctrl: RAM and modular_half stand-ins, expected writes from x*2^-s mod q.
// Works with or without HALF_SCALE_PERF_EN defined.
module tb_half_scale_ctrl;
   localparam int     DW = 24;
   localparam int     AW = 8;
   localparam int     CW = 4;
   localparam longint QK = 3329;
   localparam longint QD = 8380417;

   typedef struct {
      int          addr;
      logic [23:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   half_scale_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus_if ();
`ifdef HALF_SCALE_PERF_EN
   logic [31:0] perf_cycles;
`endif

   half_scale_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
`ifdef HALF_SCALE_PERF_EN
      ,
      .perf_cycles (perf_cycles)
`endif
   );

   logic [DW-1:0] mem [256];
   exp_t          exp_q[$];
   exp_t          mon_e;
   int            checks = 0;
   int            errors = 0;
   int            busy_cnt = 0;
   int            done_cnt = 0;
   int            exp_busy = 0;
   int            cur_n = 256;
   logic          cur_mode = 1'b0;

   // Halving by the usual even/odd rule, one lane at a time.
   function automatic logic [23:0] model_half(input logic [23:0] x, input logic m);
      longint v, lo, hi;
      if (m) begin
         v = longint'(x[22:0]);
         v = (v % 2 == 0) ? v / 2 : (v + QD) / 2;
         return 24'(v);
      end
      lo = longint'(x[11:0]);
      hi = longint'(x[23:12]);
      lo = (lo % 2 == 0) ? lo / 2 : (lo + QK) / 2;
      hi = (hi % 2 == 0) ? hi / 2 : (hi + QK) / 2;
      return {12'(hi), 12'(lo)};
   endfunction

   // Reference: multiply by (2^-1)^s mod q.
   function automatic logic [23:0] ref_scale(input logic [23:0] w, input logic m, input int s);
      longint q, f, inv, lo, hi;
      q   = m ? QD : QK;
      inv = (q + 1) / 2;
      f   = 1;
      for (int i = 0; i < s; i++) f = (f * inv) % q;
      if (m) return 24'((longint'(w[22:0]) * f) % q);
      lo = (longint'(w[11:0]) * f) % q;
      hi = (longint'(w[23:12]) * f) % q;
      return {12'(hi), 12'(lo)};
   endfunction

   function automatic logic [23:0] rand_word(input logic m);
      if (m) return {1'b0, 23'($urandom % 32'(QD))};
      return {12'($urandom % 32'(QK)), 12'($urandom % 32'(QK))};
   endfunction

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   always @(posedge clk) begin
      if (bus_if.rd_en) bus_if.rd_data <= mem[bus_if.rd_addr];
      if (bus_if.wr_en) mem[bus_if.wr_addr] = bus_if.wr_data;
   end

   always_comb bus_if.half_y = model_half(bus_if.half_x, bus_if.half_mode);

   // Monitor: pops expected writes and checks job-level properties.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus_if.rd_en || bus_if.wr_en) chk("rd_wr_exclusive", bus_if.rd_en & bus_if.wr_en, 0);
         if (bus_if.rd_en) chk("rd_addr_range", bus_if.rd_addr < cur_n, 1);
         if (bus_if.wr_en) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write actual addr=%0d data=%0d required=no write",
                        bus_if.wr_addr, bus_if.wr_data);
            end else begin
               mon_e = exp_q.pop_front();
               chk("wr_addr", bus_if.wr_addr, mon_e.addr);
               chk("wr_data", bus_if.wr_data, mon_e.data);
            end
         end
         if (bus_if.busy) begin
            busy_cnt++;
            chk("half_mode", bus_if.half_mode, cur_mode);
         end else begin
            busy_cnt = 0;
         end
         if (bus_if.done) begin
            done_cnt++;
            chk("busy_len", busy_cnt, exp_busy);
            chk("pending_writes", exp_q.size(), 0);
         end
      end
   end

   task automatic preload(input logic m);
      for (int i = 0; i < 256; i++) mem[i] = rand_word(m);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_busy"}, bus_if.busy, 0);
      chk({tag, "_done"}, bus_if.done, 0);
      chk({tag, "_rd_en"}, bus_if.rd_en, 0);
      chk({tag, "_wr_en"}, bus_if.wr_en, 0);
      chk({tag, "_rd_addr"}, bus_if.rd_addr, 0);
      chk({tag, "_wr_addr"}, bus_if.wr_addr, 0);
      chk({tag, "_wr_data"}, bus_if.wr_data, 0);
      chk({tag, "_half_x"}, bus_if.half_x, 0);
      chk({tag, "_half_mode"}, bus_if.half_mode, 0);
`ifdef HALF_SCALE_PERF_EN
      chk({tag, "_perf"}, perf_cycles, 0);
`endif
   endtask

   task automatic pulse_start(input logic m, input int s);
      @(posedge clk); #1;
      bus_if.start     = 1'b1;
      bus_if.KD_mode   = m;
      bus_if.shift_cnt = CW'(s);
      @(posedge clk); #1;
      bus_if.start     = 1'b0;
   endtask

   task automatic run_job(input logic m, input int s, input bit disturb);
      int n, d0, k;
      n = m ? 256 : 128;
      for (int a = 0; a < n; a++) exp_q.push_back('{addr: a, data: ref_scale(mem[a], m, s)});
      cur_n    = n;
      cur_mode = m;
      exp_busy = n * (3 + s) + 1;
      d0       = done_cnt;
      pulse_start(m, s);
      if (disturb) begin
         repeat (40) @(posedge clk);
         #1;
         bus_if.start     = 1'b1;
         bus_if.KD_mode   = ~m;
         bus_if.shift_cnt = CW'(s + 1);
         @(posedge clk); #1;
         bus_if.start     = 1'b0;
      end
      for (k = 0; k < 6000; k++) begin
         @(posedge clk); #1;
         if (bus_if.done) break;
      end
      if (k == 6000) begin
         checks++;
         errors++;
         $display("FAIL done_timeout actual=no done required=done within 6000 cycles");
         exp_q.delete();
      end
      @(posedge clk); #1;
      chk("done_pulses", done_cnt - d0, 1);
      chk("idle_busy", bus_if.busy, 0);
      chk("done_one_cycle", bus_if.done, 0);
`ifdef HALF_SCALE_PERF_EN
      chk("perf_cycles", perf_cycles, exp_busy);
`endif
      bus_if.KD_mode = 1'b0;
   endtask

   initial begin
      logic [23:0] saved;
      int          k;
      bus_if.start     = 1'b0;
      bus_if.KD_mode   = 1'b0;
      bus_if.shift_cnt = '0;
      bus_if.rd_data   = '0;
      for (int i = 0; i < 256; i++) mem[i] = '0;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_zero("reset");

      preload(1'b1);
      mem[0] = 24'd3;
      run_job(1'b1, 1, 1'b0);
      chk("d_s1_word0", mem[0], 4190210);

      preload(1'b1);
      mem[0] = 24'd1;
      run_job(1'b1, 2, 1'b0);
      chk("d_s2_word0", mem[0], 6285313);

      preload(1'b0);
      mem[0] = {12'd5, 12'd4};
      saved  = mem[128];
      run_job(1'b0, 1, 1'b0);
      chk("k_s1_word0", mem[0], {12'd1667, 12'd2});
      chk("k_addr128_untouched", mem[128], saved);

      preload(1'b0);
      run_job(1'b0, 0, 1'b0);
      preload(1'b1);
      run_job(1'b1, 0, 1'b0);

      preload(1'b1);
      run_job(1'b1, 2, 1'b1);
      preload(1'b0);
      run_job(1'b0, 3, 1'b1);

      for (int j = 0; j < 3; j++) begin
         logic m;
         m = 1'($urandom_range(0, 1));
         preload(m);
         run_job(m, int'($urandom_range(0, 15)), 1'b0);
      end

      // Abort during the HALVE phase of word 10.
      preload(1'b1);
      for (int a = 0; a < 10; a++) exp_q.push_back('{addr: a, data: ref_scale(mem[a], 1'b1, 3)});
      cur_n    = 256;
      cur_mode = 1'b1;
      saved    = mem[10];
      pulse_start(1'b1, 3);
      for (k = 0; k < 2000; k++) begin
         if (bus_if.wr_en && bus_if.wr_addr == 8'd9) break;
         @(posedge clk); #1;
      end
      if (k == 2000) begin
         checks++;
         errors++;
         $display("FAIL abort_wait actual=no write at 9 required=write at 9");
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check_zero("abort");
      repeat (5) @(posedge clk);
      #1;
      chk("abort_no_write10", mem[10], saved);
      chk("abort_pending", exp_q.size(), 0);
      exp_q.delete();

      preload(1'b1);
      run_job(1'b1, 1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
